// File: rtl/or_rn_2ph_pkg.sv
// Shared types and the round-robin search used by the two-phase request merger.
package or_rn_2ph_pkg;

   localparam int MAX_CH   = 16;
   localparam int CH_IDX_W = 4;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   // First set bit of pend at or after ptr, wrapping within n_ch; returns ptr if none set.
   function automatic logic [CH_IDX_W-1:0] rr_pick(
      input logic [MAX_CH-1:0]   pend,
      input logic [CH_IDX_W-1:0] ptr,
      input int                  n_ch
   );
      logic found;
      int   j;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < MAX_CH; k++) begin
         j = int'(ptr) + k;
         if (j >= n_ch) begin
            j = j - n_ch;
         end
         if ((k < n_ch) && !found && pend[j[CH_IDX_W-1:0]]) begin
            rr_pick = j[CH_IDX_W-1:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/or_rn_2ph_sync_sync_ff.sv
// Multi-bit flop synchroniser of configurable depth, cleared by synchronous reset.
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stage_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= {stage_reg[STAGES-2:0], d};
      end
   end

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/or_rn_2ph_sync.sv
// N-channel two-phase request merger with round-robin arbitration and protocol checking.
// Define OR_RN_2PH_COALESCE_EN to merge all pending channels into one output transaction.
module or_rn_2ph_sync
   import or_rn_2ph_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         r_in,
   output logic [N_CH-1:0]         a_in,
   output logic                    r_out,
   input  logic                    a_out,
   output logic [$clog2(N_CH)-1:0] grant_id,
   output logic                    busy,
   output logic                    proto_err
);

   localparam int GW = $clog2(N_CH);

   logic [N_CH-1:0]     rs;
   logic                as;
   logic [N_CH-1:0]     rs_prev_reg;
   logic                as_prev_reg;
   logic [N_CH-1:0]     a_in_reg;
   logic                r_out_reg;
   logic [GW-1:0]       grant_id_reg;
   logic                busy_reg;
   logic                proto_err_reg;
   logic [N_CH-1:0]     mask_reg;
   state_t              state_reg;

   logic [N_CH-1:0]     pend;
   logic [N_CH-1:0]     dbl_tog;
   logic                as_idle_tog;
   logic [MAX_CH-1:0]   pend_ext;
   logic [CH_IDX_W-1:0] pick_idx;
   logic [N_CH-1:0]     mask_next;

   sync_ff #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_sync_req (
      .clk (clk),
      .rst (rst),
      .d   (r_in),
      .q   (rs)
   );

   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
      .clk (clk),
      .rst (rst),
      .d   (a_out),
      .q   (as)
   );

   assign pend = rs ^ a_in_reg;

   // A fresh toggle on a channel whose previous request is still unacknowledged.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         assign dbl_tog[gi] = (rs[gi] ^ rs_prev_reg[gi]) & (rs_prev_reg[gi] ^ a_in_reg[gi]);
      end
   endgenerate

   assign as_idle_tog = (state_reg == IDLE) && (as != as_prev_reg);

   always_comb begin
      pend_ext           = '0;
      pend_ext[N_CH-1:0] = pend;
   end

`ifdef OR_RN_2PH_COALESCE_EN
   assign pick_idx  = rr_pick(pend_ext, '0, N_CH);
   assign mask_next = pend;
`else
   logic [GW-1:0]       rr_ptr_reg;
   logic [GW-1:0]       rr_ptr_next;
   logic [CH_IDX_W-1:0] ptr_ext;

   always_comb begin
      ptr_ext         = '0;
      ptr_ext[GW-1:0] = rr_ptr_reg;
   end

   assign pick_idx    = rr_pick(pend_ext, ptr_ext, N_CH);
   assign rr_ptr_next = (grant_id_reg == GW'(N_CH - 1)) ? '0 : grant_id_reg + GW'(1);

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
         assign mask_next[gi] = (pick_idx == CH_IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= '0;
      end else if ((state_reg == WAIT) && (as == r_out_reg)) begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_prev_reg   <= '0;
         as_prev_reg   <= 1'b0;
         a_in_reg      <= '0;
         r_out_reg     <= 1'b0;
         grant_id_reg  <= '0;
         busy_reg      <= 1'b0;
         proto_err_reg <= 1'b0;
         mask_reg      <= '0;
         state_reg     <= IDLE;
      end else begin
         rs_prev_reg <= rs;
         as_prev_reg <= as;
         if ((|dbl_tog) || as_idle_tog) begin
            proto_err_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (|pend) begin
                  mask_reg     <= mask_next;
                  grant_id_reg <= GW'(pick_idx);
                  r_out_reg    <= ~r_out_reg;
                  busy_reg     <= 1'b1;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (as == r_out_reg) begin
                  a_in_reg  <= a_in_reg ^ mask_reg;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign a_in      = a_in_reg;
   assign r_out     = r_out_reg;
   assign grant_id  = grant_id_reg;
   assign busy      = busy_reg;
   assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_or_rn_2ph_sync.sv
// Self-checking bench for or_rn_2ph_sync: vector table plus scoreboard of expected transactions.
module tb_or_rn_2ph_sync;

   localparam int N_CH = 4;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] r_in;
   logic [3:0] a_in;
   logic       r_out;
   logic       a_out;
   logic [1:0] grant_id;
   logic       busy;
   logic       proto_err;

   or_rn_2ph_sync #(.N_CH(N_CH), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .rst       (rst),
      .r_in      (r_in),
      .a_in      (a_in),
      .r_out     (r_out),
      .a_out     (a_out),
      .grant_id  (grant_id),
      .busy      (busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] mask;
      logic [1:0] gid;
   } exp_t;

   typedef struct packed {
      logic [3:0]      tog;
      logic [1:0]      dly;
      logic [2:0]      n;
      logic [3:0][3:0] masks;
      logic [3:0][1:0] gids;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[$];

   function automatic vec_t mkv(input logic [3:0] tog, input logic [1:0] dly,
                                input logic [3:0] m0, input logic [1:0] g0,
                                input logic [3:0] m1, input logic [1:0] g1,
                                input logic [3:0] m2, input logic [1:0] g2,
                                input logic [3:0] m3, input logic [1:0] g3);
      vec_t v;
      v.tog      = tog;
      v.dly      = dly;
      v.masks[0] = m0; v.gids[0] = g0;
      v.masks[1] = m1; v.gids[1] = g1;
      v.masks[2] = m2; v.gids[2] = g2;
      v.masks[3] = m3; v.gids[3] = g3;
      v.n        = 3'(int'(m0 != 0) + int'(m1 != 0) + int'(m2 != 0) + int'(m3 != 0));
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst   = 1'b1;
      r_in  = '0;
      a_out = 1'b0;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic wait_r_out(input logic r_prev, output logic found);
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (r_out !== r_prev) begin
            found = 1'b1;
            break;
         end
      end
      chk("req_seen", 32'(found), 32'd1);
   endtask

   // Consumer: waits for r_out, checks against the scoreboard, echoes after dly cycles.
   task automatic serve(input int dly, input logic [3:0] late, input exp_t late_exp,
                        output int t_req, output int t_done);
      logic       found;
      logic [3:0] a_prev;
      exp_t       e;
      int         t_ack;
      t_req  = cyc;
      t_done = cyc;
      wait_r_out(r_out, found);
      if (!found) return;
      t_req = cyc;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow actual=empty required=entry");
         return;
      end
      e = sbq.pop_front();
      chk("grant_id", 32'(grant_id), 32'(e.gid));
      chk("busy_hi", 32'(busy), 32'd1);
      if (late != 0) begin
         r_in = r_in ^ late;
         sbq.push_back(late_exp);
      end
      repeat (dly) tick();
      a_prev = a_in;
      a_out  = r_out;
      t_ack  = cyc;
      found  = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (a_in !== a_prev) begin
            found = 1'b1;
            break;
         end
      end
      chk("ack_seen", 32'(found), 32'd1);
      chk("ack_mask", 32'(a_in ^ a_prev), 32'(e.mask));
      chk("ack_lat", 32'(cyc - t_ack), 32'(SYNC + 1));
      chk("busy_lo", 32'(busy), 32'd0);
      t_done = cyc;
      $display("txn gid=%0d mask=%b req_cyc=%0d done_cyc=%0d", grant_id, a_in ^ a_prev, t_req, t_done);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   t0, tr, td, tr2, td2;
      logic found;
      vec_t v;

      do_reset(4);
      chk("rst_a_in", 32'(a_in), 32'd0);
      chk("rst_r_out", 32'(r_out), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      tick();

      // Single request on channel 2, consumer echoes three cycles later.
      t0   = cyc;
      r_in = r_in ^ 4'b0100;
      sbq.push_back('{mask: 4'b0100, gid: 2'd2});
      serve(3, 4'b0000, '0, tr, td);
      chk("r_out_lat", 32'(tr - t0), 32'(SYNC + 1));
      chk("turnaround", 32'(td - t0), 32'(2 * SYNC + 2 + 3));
      chk("proto_clean", 32'(proto_err), 32'd0);

`ifdef OR_RN_2PH_COALESCE_EN
      vecs.push_back(mkv(4'b1011, 2'd1, 4'b1011, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b0011, 2'd0, 4'b0011, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b1001, 2'd2, 4'b1001, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b0110, 2'd3, 4'b0110, 2'd1, 4'b0, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b1111, 2'd1, 4'b1111, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
`else
      vecs.push_back(mkv(4'b1011, 2'd1, 4'b0001, 2'd0, 4'b0010, 2'd1, 4'b1000, 2'd3, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b0011, 2'd0, 4'b0001, 2'd0, 4'b0010, 2'd1, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b1001, 2'd2, 4'b1000, 2'd3, 4'b0001, 2'd0, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b0110, 2'd3, 4'b0010, 2'd1, 4'b0100, 2'd2, 4'b0, 2'd0, 4'b0, 2'd0));
      vecs.push_back(mkv(4'b1111, 2'd1, 4'b1000, 2'd3, 4'b0001, 2'd0, 4'b0010, 2'd1, 4'b0100, 2'd2));
`endif

      // Contention table, starting from a freshly reset arbiter.
      do_reset(4);
      tick();
      for (int i = 0; i < vecs.size(); i++) begin
         v    = vecs[i];
         r_in = r_in ^ v.tog;
         for (int j = 0; j < int'(v.n); j++) begin
            sbq.push_back('{mask: v.masks[j], gid: v.gids[j]});
         end
         for (int j = 0; j < int'(v.n); j++) begin
            serve(int'(v.dly), 4'b0000, '0, tr, td);
         end
         repeat (2) tick();
         chk("all_acked", 32'(a_in), 32'(r_in));
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Late arrival on channel 3 while channel 0 is outstanding.
      sbq.push_back('{mask: 4'b0001, gid: 2'd0});
      r_in = r_in ^ 4'b0001;
      serve(2, 4'b1000, '{mask: 4'b1000, gid: 2'd3}, tr, td);
      serve(1, 4'b0000, '0, tr2, td2);
      chk("b2b_gap", 32'(tr2 - td), 32'd1);
      chk("proto_clean2", 32'(proto_err), 32'd0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      // Double toggle on channel 1 without acknowledge.
      r_in = r_in ^ 4'b0010;
      repeat (4) tick();
      r_in = r_in ^ 4'b0010;
      repeat (4) tick();
      chk("proto_dbl", 32'(proto_err), 32'd1);
      repeat (10) tick();
      chk("proto_sticky", 32'(proto_err), 32'd1);
      do_reset(4);
      chk("proto_rst", 32'(proto_err), 32'd0);

      // Spurious acknowledge toggle while idle.
      a_out = 1'b1;
      repeat (5) tick();
      chk("proto_ack_idle", 32'(proto_err), 32'd1);
      do_reset(4);
      chk("proto_rst2", 32'(proto_err), 32'd0);
      tick();

      // Reset while a transaction is outstanding.
      r_in = r_in ^ 4'b0100;
      wait_r_out(r_out, found);
      chk("mid_busy", 32'(busy), 32'd1);
      rst   = 1'b1;
      r_in  = '0;
      a_out = 1'b0;
      tick();
      chk("mid_r_out", 32'(r_out), 32'd0);
      chk("mid_a_in", 32'(a_in), 32'd0);
      chk("mid_busy_lo", 32'(busy), 32'd0);
      chk("mid_grant_id", 32'(grant_id), 32'd0);
      chk("mid_proto", 32'(proto_err), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      sbq.push_back('{mask: 4'b0010, gid: 2'd1});
      r_in = r_in ^ 4'b0010;
      serve(1, 4'b0000, '0, tr, td);
      chk("post_rst_acked", 32'(a_in), 32'(r_in));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
